stopwatch_core: RTL

//  Parametrised mm:ss time engine replacing the fixed up-counter behind the display path.

---
 rtl/stopwatch_core_if.sv | 58 +++++
 rtl/stopwatch_core.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core_if.sv
// Control strobes/levels into the mm:ss time engine and
// the BCD display/status bundle coming back out of it.
interface stopwatch_core_if;
  logic       sec_tick;
  logic       adj_tick;
  logic       pause_pulse;
  logic       lap_pulse;
  logic       adj;
  logic       sel;
  logic       dir;
  logic [3:0] mt;
  logic [3:0] mo;
  logic [3:0] st;
  logic [3:0] so;
  logic       running;
  logic       adj_mode;
  logic       blink;
  logic       lap_active;
  logic       done;

  modport master (
    output sec_tick,
    output adj_tick,
    output pause_pulse,
    output lap_pulse,
    output adj,
    output sel,
    output dir,
    input  mt,
    input  mo,
    input  st,
    input  so,
    input  running,
    input  adj_mode,
    input  blink,
    input  lap_active,
    input  done
  );

  modport slave (
    input  sec_tick,
    input  adj_tick,
    input  pause_pulse,
    input  lap_pulse,
    input  adj,
    input  sel,
    input  dir,
    output mt,
    output mo,
    output st,
    output so,
    output running,
    output adj_mode,
    output blink,
    output lap_active,
    output done
  );
endinterface

// File: rtl/stopwatch_core.sv
// mm:ss stopwatch/countdown engine with lap freeze and
// per-field adjust; all timing from clk-domain strobes.
module stopwatch_core #(
  parameter int MIN_MAX = 59,
  parameter int LAP_EN  = 1,
  parameter int DOWN_EN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  stopwatch_core_if.slave  sw
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [6:0] MAX_M = 7'(MIN_MAX);
  localparam logic [5:0] MAX_S = 6'd59;
  localparam bit HAS_LAP  = (LAP_EN != 0);
  localparam bit HAS_DOWN = (DOWN_EN != 0);

  state_t     state_q, state_d;
  logic [6:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       lap_q, lap_d;
  logic [6:0] lap_min_q, lap_min_d;
  logic [5:0] lap_sec_q, lap_sec_d;
  logic       blink_q, blink_d;
  logic       done_q, done_d;

  logic       down;
  logic [6:0] disp_min;
  logic [6:0] disp_sec;

  function automatic logic [7:0] to_bcd(
    input logic [6:0] v
  );
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

  assign down = HAS_DOWN && sw.dir;

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    lap_d     = lap_q;
    lap_min_d = lap_min_q;
    lap_sec_d = lap_sec_q;
    blink_d   = 1'b0;
    done_d    = 1'b0;

    if (sw.adj) begin
      state_d = ST_ADJ;
      lap_d   = 1'b0;
      if (state_q == ST_ADJ) begin
        blink_d = blink_q;
        if (sw.adj_tick) begin
          blink_d = ~blink_q;
          if (sw.sel) begin
            sec_d = (sec_q == MAX_S)
                  ? 6'd0 : sec_q + 6'd1;
          end else begin
            min_d = (min_q == MAX_M)
                  ? 7'd0 : min_q + 7'd1;
          end
        end
      end
    end else begin
      unique case (state_q)
        ST_ADJ: state_d = ST_PAUSE;

        ST_RUN: begin
          if (sw.sec_tick) begin
            if (down) begin
              // 00:01 and 00:00 both land on 00:00 and finish
              if (min_q == 7'd0 && sec_q <= 6'd1) begin
                sec_d   = 6'd0;
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else if (sec_q == 6'd0) begin
                min_d = min_q - 7'd1;
                sec_d = MAX_S;
              end else begin
                sec_d = sec_q - 6'd1;
              end
            end else if (sec_q == MAX_S) begin
              sec_d = 6'd0;
              min_d = (min_q == MAX_M)
                    ? 7'd0 : min_q + 7'd1;
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end
          if (sw.pause_pulse) begin
            state_d = ST_PAUSE;
          end else if (sw.lap_pulse && HAS_LAP) begin
            lap_d = ~lap_q;
            if (!lap_q) begin
              lap_min_d = min_q;
              lap_sec_d = sec_q;
            end
          end
        end

        ST_PAUSE: begin
          if (sw.pause_pulse) begin
            state_d = ST_RUN;
          end else if (sw.lap_pulse) begin
            lap_d = 1'b0;
          end
        end

        ST_DONE: begin
          if (sw.pause_pulse) begin
            state_d = ST_PAUSE;
          end
        end

        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      min_q     <= 7'd0;
      sec_q     <= 6'd0;
      lap_q     <= 1'b0;
      lap_min_q <= 7'd0;
      lap_sec_q <= 6'd0;
      blink_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      lap_q     <= lap_d;
      lap_min_q <= lap_min_d;
      lap_sec_q <= lap_sec_d;
      blink_q   <= blink_d;
      done_q    <= done_d;
    end
  end

  assign disp_min = lap_q ? lap_min_q : min_q;
  assign disp_sec = lap_q ? {1'b0, lap_sec_q}
                          : {1'b0, sec_q};

  assign {sw.mt, sw.mo} = to_bcd(disp_min);
  assign {sw.st, sw.so} = to_bcd(disp_sec);

  assign sw.running    = (state_q == ST_RUN);
  assign sw.adj_mode   = (state_q == ST_ADJ);
  assign sw.blink      = blink_q;
  assign sw.lap_active = lap_q;
  assign sw.done       = done_q;

endmodule
